// File: rtl/prog_loader.sv
// Byte-stream program loader: fills the instruction or data memory, holds the CPU in reset,
// releases it for a fixed number of cycles, then halts it again until the next session.
module prog_loader #(
  parameter int ADDR_W     = 10,
  parameter int RUN_CYCLES = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              start_sel,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              overflow,
  output logic [31:0]       run_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, HALT} state_t;

  localparam logic [31:0] LAST_CNT = 32'(RUN_CYCLES - 1);

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic                accept;
  logic                ptr_full;

  assign in_ready = (state == LOAD);
  assign accept   = in_ready & in_valid;
  assign ptr_full = &ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      overflow  <= 1'b0;
      run_cnt   <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state    <= LOAD;
            ptr      <= '0;
            mem_sel  <= start_sel;
            overflow <= 1'b0;
            done     <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= in_data;
            // The top address ends the session either way; the pointer never wraps.
            if (!ptr_full) ptr <= ptr + 1'b1;
            if (in_last || ptr_full) begin
              state    <= RELEASE;
              overflow <= ptr_full & ~in_last;
            end
          end
        end
        RELEASE: begin
          state   <= RUN;
          cpu_rst <= 1'b0;
          run_cnt <= '0;
        end
        RUN: begin
          if (run_cnt == LAST_CNT) begin
            state   <= HALT;
            cpu_rst <= 1'b1;
            done    <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: stream-level model of which bytes land where, plus run length.
module tb_prog_loader;
  localparam int ADDR_W     = 2;
  localparam int RUN_CYCLES = 200;
  localparam int CAP        = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst, start, start_sel, in_valid, in_last;
  logic [7:0]        in_data;
  logic              in_ready, mem_we, mem_sel, cpu_rst, done, overflow;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [31:0]       run_cnt;

  int nchk = 0;
  int nerr = 0;
  logic [7:0] bytes[$];

  prog_loader #(.ADDR_W(ADDR_W), .RUN_CYCLES(RUN_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start), .start_sel(start_sel),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .done(done), .overflow(overflow), .run_cnt(run_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; start = 1'b0; start_sel = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_sel", mem_sel, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_run_cnt", run_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // vmode: 0 valid every cycle, 1 random valid, 2 fixed pattern 1,0,0,1,1.
  // abort: 0 none, 1 reset right after the first write, 2 reset at run_cnt 50.
  task automatic session(input bit sel, input int vmode, input bit hold_start, input int abort);
    int n, exp_acc, acc, cyc, cnt;
    bit ovf, v;
    logic [4:0] pat;
    pat     = 5'b11001;
    n       = bytes.size();
    exp_acc = (n < CAP) ? n : CAP;
    ovf     = (n > CAP);
    acc     = 0;
    cyc     = 0;
    start = 1'b1; start_sel = sel;
    @(negedge clk);
    start = hold_start;
    start_sel = ~sel;
    chk("load_done_clr", done, 0);
    chk("load_ovf_clr", overflow, 0);
    while (acc < exp_acc && cyc < 64) begin
      chk("in_ready_load", in_ready, 1);
      case (vmode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 2) != 0);
        default: v = pat[cyc % 5];
      endcase
      in_valid = v; in_data = bytes[acc]; in_last = (acc == n - 1);
      @(negedge clk);
      cyc++;
      chk("mem_we", mem_we, 32'(v));
      if (v) begin
        chk("mem_addr", mem_addr, acc);
        chk("mem_wdata", mem_wdata, bytes[acc]);
        chk("mem_sel", mem_sel, 32'(sel));
        acc++;
        if (abort == 1) begin
          rst = 1'b0;
          #1;
          chk("abort_load_we", mem_we, 0);
          chk("abort_load_rdy", in_ready, 0);
          chk("abort_load_cpu_rst", cpu_rst, 1);
          chk("abort_load_sel", mem_sel, 0);
          return;
        end
      end
    end
    chk("load_count", acc, exp_acc);
    // Keep offering the surplus byte after an overflow: it must never be taken.
    in_valid = ovf; in_last = ovf;
    if (ovf) in_data = bytes[CAP];
    chk("release_rdy", in_ready, 0);
    chk("release_cpu_rst", cpu_rst, 1);
    chk("release_ovf", overflow, 32'(ovf));
    @(negedge clk);
    cnt = 0;
    while (cpu_rst === 1'b0 && cnt < 1000) begin
      chk("run_cnt", run_cnt, cnt);
      chk("run_we", mem_we, 0);
      chk("run_rdy", in_ready, 0);
      if (abort == 2 && cnt == 50) begin
        rst = 1'b0;
        #1;
        chk("abort_run_cpu_rst", cpu_rst, 1);
        chk("abort_run_cnt", run_cnt, 0);
        chk("abort_run_done", done, 0);
        chk("abort_run_rdy", in_ready, 0);
        return;
      end
      cnt++;
      in_valid = ovf | 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    chk("run_len", cnt, RUN_CYCLES);
    chk("halt_done", done, 1);
    chk("halt_run_cnt", run_cnt, RUN_CYCLES - 1);
    chk("halt_ovf", overflow, 32'(ovf));
    chk("halt_we", mem_we, 0);
    @(negedge clk);
    chk("halt_hold_done", done, 1);
    chk("halt_hold_cnt", run_cnt, RUN_CYCLES - 1);
    chk("halt_hold_cpu_rst", cpu_rst, 1);
    chk("halt_hold_rdy", in_ready, 0);
  endtask

  task automatic rand_bytes(input int n);
    bytes.delete();
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; start_sel = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    do_reset();

    // Full-memory stream with last on the top address: no overflow.
    bytes = '{8'h20, 8'h08, 8'h00, 8'h01};
    session(1'b0, 0, 1'b0, 0);
    // Restart straight from HALT, gapped valid, start held through the run.
    rand_bytes(3);
    session(1'b1, 2, 1'b1, 0);
    // Five bytes into four locations.
    rand_bytes(5);
    session(1'b0, 0, 1'b0, 0);

    rand_bytes(3);
    session(1'b0, 0, 1'b0, 2);
    do_reset();
    rand_bytes(2);
    session(1'b1, 0, 1'b0, 0);

    rand_bytes(3);
    session(1'b1, 1, 1'b0, 1);
    do_reset();
    rand_bytes(1);
    session(1'b0, 0, 1'b0, 0);

    for (int s = 0; s < 6; s++) begin
      rand_bytes($urandom_range(1, 6));
      session(1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 10, byte-address width of target memory (1024 bytes).
REQ-002 Parameter RUN_CYCLES, default 200, CPU run length in clk cycles before halt.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  begin load session; sampled only in IDLE or HALT.
REQ-006 start_sel  input  1  target select latched with start: 0 instruction memory, 1 data memory.
REQ-007 in_valid  input  1  byte on in_data valid.
REQ-008 in_data  input  8  load byte, little-endian stream order.
REQ-009 in_last  input  1  marks final byte of session.
REQ-010 in_ready  output  1  loader accepts byte this cycle.
REQ-011 mem_we  output  1  byte write strobe to target memory.
REQ-012 mem_sel  output  1  latched target select.
REQ-013 mem_addr  output  ADDR_W  byte address of write.
REQ-014 mem_wdata  output  8  byte written.
REQ-015 cpu_rst  output  1  CPU reset, active-high.
REQ-016 done  output  1  run complete, level.
REQ-017 overflow  output  1  memory filled before in_last seen.
REQ-018 run_cnt  output  32  CPU cycles elapsed in current run.

Function
REQ-019 FSM states IDLE, LOAD, RELEASE, RUN, HALT; IDLE after reset.
REQ-020 IDLE: in_ready=0, cpu_rst=1; start=1 -> LOAD next cycle, write pointer cleared to 0, start_sel latched into mem_sel, overflow cleared.
REQ-021 LOAD: in_ready=1 combinationally in LOAD; a byte is accepted on a cycle with in_valid=1 and in_ready=1.
REQ-022 Accepted byte produces mem_we=1, mem_addr=pointer, mem_wdata=byte on the following cycle (1-cycle registered latency); pointer increments by 1.
REQ-023 mem_we=0 on every cycle not following an acceptance; back-to-back acceptances yield consecutive write cycles, no bubbles.
REQ-024 in_valid=0 in LOAD: no acceptance, pointer holds, state holds.
REQ-025 Acceptance with in_last=1 -> RELEASE next cycle.
REQ-026 Acceptance at pointer 2^ADDR_W-1 with in_last=0 -> RELEASE next cycle, overflow=1; pointer does not wrap, no further bytes accepted.
REQ-027 Acceptance at pointer 2^ADDR_W-1 with in_last=1 -> RELEASE, overflow stays 0.
REQ-028 RELEASE: exactly one cycle, in_ready=0, cpu_rst=1 (final pipelined write completes here); then RUN.
REQ-029 RUN: cpu_rst=0; run_cnt cleared to 0 on entry, increments by 1 each RUN cycle; start ignored.
REQ-030 RUN with run_cnt=RUN_CYCLES-1 -> HALT next cycle; CPU thus sees exactly RUN_CYCLES cycles out of reset.
REQ-031 HALT: cpu_rst=1, done=1, run_cnt holds final value RUN_CYCLES-1, overflow holds.
REQ-032 HALT with start=1 -> LOAD as in REQ-020; done cleared on that transition.
REQ-033 start in LOAD, RELEASE, RUN ignored; in_valid outside LOAD ignored and never acknowledged.

Reset
REQ-034 rst=0 asynchronously forces IDLE, in_ready=0, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, overflow=0, run_cnt=0, pointer=0.
REQ-035 rst asserted mid-LOAD or mid-RUN aborts session; pending registered write is discarded (mem_we=0 immediately).
REQ-036 After rst release, first cycle sits in IDLE; start on that cycle is honoured.

Verification
REQ-037 start=1, start_sel=0, stream 0x20,0x08,0x00,0x01 (last on 4th), in_valid continuous -> mem_we on 4 consecutive cycles, addr 0..3, data in order, mem_sel=0, RELEASE then cpu_rst falls.
REQ-038 RUN_CYCLES=200 after load -> cpu_rst=0 for exactly 200 cycles, done=1 and run_cnt=199 on HALT entry.
REQ-039 ADDR_W=2, stream 5 bytes, in_last only on 5th -> 4 writes addr 0..3, overflow=1, in_ready=0 after 4th acceptance, 5th byte never accepted.
REQ-040 in_valid toggled 1,0,0,1,1 with in_last on final -> writes only after valid cycles, addresses 0,1,2 contiguous.
REQ-041 rst pulsed low during RUN at run_cnt=50 -> immediate cpu_rst=1, run_cnt=0, state IDLE; new start with start_sel=1 loads with mem_sel=1.
REQ-042 start held high throughout RUN -> no effect; from HALT, start -> LOAD, done=0, pointer 0.
